// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner
// encodings and the memory read latency.
package mem_port_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } arb_state_t;

    // Owner encodings: who holds (or last held) the memory port.
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Edges from mem_addr being presented to mem_rdata being valid.
    // The RD1/RD2 pair of states covers exactly this latency.
    localparam int READ_LATENCY = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-input round-robin picker. A lone request wins outright;
// when both requesters are active, the one that is not the current owner wins.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
    input  logic owner,
    output logic grant_valid,
    output logic grant_owner
);

    // Pick a winner from the current requests and the last owner.
    always_comb begin
        grant_valid = f_req | d_req;
        grant_owner = OWN_FETCH;
        if (f_req && d_req) begin
            grant_owner = ~owner;
        end else if (d_req) begin
            grant_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto a single synchronous memory.
// Reads take IDLE->RD1->RD2->RESP, writes take IDLE->WR->RESP; every output is
// a register. Requests are sampled only in IDLE and a granted transaction
// always runs to completion.
//
// Handshake: a requester raises its req and holds it until it samples its
// one-cycle done pulse. The done pulse is loaded on the RESP->IDLE edge, so it
// is visible during the first IDLE cycle after RESP. A req still high in that
// IDLE cycle is arbitrated as a fresh request.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        f_done,
    output logic        d_done,
    output logic        busy,
    output logic        owner,
    output arb_state_t  debug_state
);

    arb_state_t  state;
    arb_state_t  state_n;
    logic [31:0] mem_addr_n;
    logic [31:0] mem_wdata_n;
    logic        mem_we_n;
    logic [31:0] rdata_n;
    logic        f_done_n;
    logic        d_done_n;
    logic        owner_n;
    logic        grant_valid;
    logic        grant_owner;

    mem_arb_pick u_pick (
        .f_req       (f_req),
        .d_req       (d_req),
        .owner       (owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n     = state;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_we_n    = 1'b0;
        rdata_n     = rdata;
        f_done_n    = 1'b0;
        d_done_n    = 1'b0;
        owner_n     = owner;
        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_n = grant_owner;
                    if (grant_owner == OWN_FETCH) begin
                        mem_addr_n = f_addr;
                        state_n    = ST_RD1;
                    end else begin
                        mem_addr_n  = d_addr;
                        mem_wdata_n = d_wdata;
                        if (d_we) begin
                            mem_we_n = 1'b1;
                            state_n  = ST_WR;
                        end else begin
                            state_n = ST_RD1;
                        end
                    end
                end
            end
            ST_RD1: begin
                state_n = ST_RD2;
            end
            ST_RD2: begin
                // mem_rdata is valid READ_LATENCY edges after mem_addr.
                rdata_n = mem_rdata;
                state_n = ST_RESP;
            end
            ST_WR: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                f_done_n = (owner == OWN_FETCH);
                d_done_n = (owner == OWN_DATA);
                state_n  = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output registers; reset clears everything so no done pulse survives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
            owner     <= OWN_FETCH;
        end else begin
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_we    <= mem_we_n;
            rdata     <= rdata_n;
            f_done    <= f_done_n;
            d_done    <= d_done_n;
            busy      <= (state_n != ST_IDLE);
            owner     <= owner_n;
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1ns after a rising edge,
// outputs are checked at that same point, well away from the active edge.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        f_done;
    logic        d_done;
    logic        busy;
    logic        owner;
    arb_state_t  debug_state;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .rdata       (rdata),
        .f_done      (f_done),
        .d_done      (d_done),
        .busy        (busy),
        .owner       (owner),
        .debug_state (debug_state)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_st(input string tag, input arb_state_t exp);
        chk(tag, 32'(debug_state), 32'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        f_req     = 1'b0;
        f_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;

        // Reset state.
        #3;
        chk("rst_state", 32'(debug_state), 32'(ST_IDLE));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Fetch read of 0x4.
        f_req     = 1'b1;
        f_addr    = 32'h0000_0004;
        mem_rdata = 32'h8C22_0010;
        tick();
        chk("rd_mem_addr", mem_addr, 32'h4);
        chk("rd_owner", {31'd0, owner}, 32'd0);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        chk_st("rd_st_rd1", ST_RD1);
        tick();
        chk_st("rd_st_rd2", ST_RD2);
        chk("rd_fdone_early1", {31'd0, f_done}, 32'd0);
        tick();
        chk_st("rd_st_resp", ST_RESP);
        chk("rd_rdata", rdata, 32'h8C22_0010);
        chk("rd_fdone_early2", {31'd0, f_done}, 32'd0);
        tick();
        chk("rd_fdone", {31'd0, f_done}, 32'd1);
        chk("rd_ddone", {31'd0, d_done}, 32'd0);
        chk("rd_busy_idle", {31'd0, busy}, 32'd0);
        f_req = 1'b0;
        tick();
        chk("rd_fdone_once", {31'd0, f_done}, 32'd0);
        chk_st("rd_idle_after", ST_IDLE);

        // Data write of 0xDEADBEEF to 0x40.
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_0040;
        d_wdata   = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_AAAA;
        tick();
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h40);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("wr_owner", {31'd0, owner}, 32'd1);
        chk_st("wr_st_wr", ST_WR);
        tick();
        chk("wr_mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk("wr_ddone_early", {31'd0, d_done}, 32'd0);
        tick();
        chk("wr_ddone", {31'd0, d_done}, 32'd1);
        chk("wr_fdone", {31'd0, f_done}, 32'd0);
        chk("wr_rdata_kept", rdata, 32'h8C22_0010);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        chk("wr_ddone_once", {31'd0, d_done}, 32'd0);

        // Contention straight after reset: data first, then strict alternation.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        f_req     = 1'b1;
        f_addr    = 32'h0000_0100;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0080;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("ct1_owner", {31'd0, owner}, 32'd1);
        chk("ct1_addr", mem_addr, 32'h80);
        tick();
        tick();
        tick();
        chk("ct1_ddone", {31'd0, d_done}, 32'd1);
        chk("ct1_fdone", {31'd0, f_done}, 32'd0);
        tick();
        chk("ct2_owner", {31'd0, owner}, 32'd0);
        chk("ct2_addr", mem_addr, 32'h100);
        tick();
        tick();
        tick();
        chk("ct2_fdone", {31'd0, f_done}, 32'd1);
        chk("ct2_ddone", {31'd0, d_done}, 32'd0);
        tick();
        chk("ct3_owner", {31'd0, owner}, 32'd1);
        tick();
        tick();
        tick();
        chk("ct3_ddone", {31'd0, d_done}, 32'd1);
        tick();
        chk("ct4_owner", {31'd0, owner}, 32'd0);
        chk("ct4_addr", mem_addr, 32'h100);
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        tick();
        chk("ct4_fdone", {31'd0, f_done}, 32'd1);
        chk("ct4_rdata", rdata, 32'h1234_5678);
        tick();

        // Reset asserted during RD2 takes effect without a clock edge.
        f_req     = 1'b1;
        f_addr    = 32'h0000_0008;
        mem_rdata = 32'h1111_2222;
        tick();
        tick();
        chk_st("rr_st_rd2", ST_RD2);
        reset = 1'b1;
        #1;
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_fdone", {31'd0, f_done}, 32'd0);
        chk("rr_ddone", {31'd0, d_done}, 32'd0);
        chk("rr_rdata", rdata, 32'h0);
        chk_st("rr_state", ST_IDLE);
        f_req = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        chk("rr_no_done", {31'd0, f_done}, 32'd0);

        // Restart with a data read, dropping d_req during RD1.
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_000C;
        mem_rdata = 32'h3333_4444;
        tick();
        chk_st("dr_st_rd1", ST_RD1);
        chk("dr_addr", mem_addr, 32'hC);
        chk("dr_owner", {31'd0, owner}, 32'd1);
        d_req = 1'b0;
        tick();
        tick();
        chk("dr_rdata", rdata, 32'h3333_4444);
        tick();
        chk("dr_ddone", {31'd0, d_done}, 32'd1);
        tick();
        chk("dr_ddone_once", {31'd0, d_done}, 32'd0);
        chk("dr_busy", {31'd0, busy}, 32'd0);
        tick();
        chk_st("dr_no_regrant", ST_IDLE);
        chk("dr_ddone_none", {31'd0, d_done}, 32'd0);

        // Reset during WR drops mem_we at once and no done follows.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0020;
        d_wdata = 32'h0BAD_F00D;
        tick();
        chk("rw_mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rw_wdata", mem_wdata, 32'h0);
        d_req = 1'b0;
        d_we  = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        tick();
        chk("rw_no_ddone", {31'd0, d_done}, 32'd0);
        chk("rw_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
